// File: rtl/multicycle_control.sv
// Control FSM for the multi-cycle CPU datapath: sequences fetch/decode/execute/memory/writeback,
// stalls on the memory ready handshake and traps unknown opcodes into HALT.
module multicycle_control #(
  parameter int unsigned OPW = 6,
  parameter int unsigned SW_ = 4
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic [OPW-1:0] i_opcode,
  input  logic           i_zero,
  input  logic           i_mem_ready,
  output logic           o_pc_write,
  output logic           o_ir_write,
  output logic           o_ab_write,
  output logic           o_mdr_write,
  output logic           o_alu_out_write,
  output logic           o_mem_read,
  output logic           o_mem_write,
  output logic           o_iord,
  output logic           o_reg_write,
  output logic           o_reg_dst,
  output logic           o_mem_to_reg,
  output logic           o_alu_src_a,
  output logic [1:0]     o_alu_src_b,
  output logic [1:0]     o_alu_op,
  output logic [1:0]     o_pc_source,
  output logic           o_halted,
  output logic [SW_-1:0] o_state
);

  localparam logic [OPW-1:0] OpR    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OpLw   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OpSw   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OpBeq  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OpJ    = OPW'(6'b000010);
  localparam logic [OPW-1:0] OpAddi = OPW'(6'b001000);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRead = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecR   = 4'd6,
    StRWb     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StExecI   = 4'd10,
    StIWb     = 4'd11,
    StHalt    = 4'd12
  } state_e;

  state_e r_state;
  state_e w_state_next;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    o_pc_write      = 1'b0;
    o_ir_write      = 1'b0;
    o_ab_write      = 1'b0;
    o_mdr_write     = 1'b0;
    o_alu_out_write = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_iord          = 1'b0;
    o_reg_write     = 1'b0;
    o_reg_dst       = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = 2'b00;
    o_alu_op        = 2'b00;
    o_pc_source     = 2'b00;
    o_halted        = 1'b0;

    unique case (r_state)
      StFetch: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = 2'b01;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
        if (i_mem_ready) w_state_next = StDecode;
      end
      StDecode: begin
        // Branch target is precomputed into ALUOut while the opcode is decoded.
        o_ab_write      = 1'b1;
        o_alu_out_write = 1'b1;
        o_alu_src_b     = 2'b11;
        case (i_opcode)
          OpR:         w_state_next = StExecR;
          OpLw, OpSw:  w_state_next = StMemAddr;
          OpBeq:       w_state_next = StBranch;
          OpJ:         w_state_next = StJump;
          OpAddi:      w_state_next = StExecI;
          default:     w_state_next = StHalt;
        endcase
      end
      StMemAddr: begin
        o_alu_src_a     = 1'b1;
        o_alu_src_b     = 2'b10;
        o_alu_out_write = 1'b1;
        if (i_opcode == OpLw)      w_state_next = StMemRead;
        else if (i_opcode == OpSw) w_state_next = StMemWr;
        else                       w_state_next = StHalt;
      end
      StMemRead: begin
        o_mem_read  = 1'b1;
        o_iord      = 1'b1;
        o_mdr_write = i_mem_ready;
        if (i_mem_ready) w_state_next = StMemWb;
      end
      StMemWb: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
        w_state_next = StFetch;
      end
      StMemWr: begin
        o_mem_write = 1'b1;
        o_iord      = 1'b1;
        if (i_mem_ready) w_state_next = StFetch;
      end
      StExecR: begin
        o_alu_src_a     = 1'b1;
        o_alu_op        = 2'b10;
        o_alu_out_write = 1'b1;
        w_state_next    = StRWb;
      end
      StRWb: begin
        o_reg_write  = 1'b1;
        o_reg_dst    = 1'b1;
        w_state_next = StFetch;
      end
      StBranch: begin
        o_alu_src_a  = 1'b1;
        o_alu_op     = 2'b01;
        o_pc_source  = 2'b01;
        o_pc_write   = i_zero;
        w_state_next = StFetch;
      end
      StJump: begin
        o_pc_source  = 2'b10;
        o_pc_write   = 1'b1;
        w_state_next = StFetch;
      end
      StExecI: begin
        o_alu_src_a     = 1'b1;
        o_alu_src_b     = 2'b10;
        o_alu_out_write = 1'b1;
        w_state_next    = StIWb;
      end
      StIWb: begin
        o_reg_write  = 1'b1;
        w_state_next = StFetch;
      end
      StHalt: begin
        o_halted = 1'b1;
      end
      default: begin
        w_state_next = StHalt;
      end
    endcase

    // Reset abandons the instruction: nothing may be written or requested on the reset edge.
    if (i_reset) begin
      o_pc_write      = 1'b0;
      o_ir_write      = 1'b0;
      o_ab_write      = 1'b0;
      o_mdr_write     = 1'b0;
      o_alu_out_write = 1'b0;
      o_mem_read      = 1'b0;
      o_mem_write     = 1'b0;
      o_reg_write     = 1'b0;
    end
  end

  assign o_state = SW_'(r_state);

endmodule
